paralelo_serial: RTL and testbench
==================================

# paralelo_serial

Parallel-to-serial transmitter for the serial link: takes 8-bit bytes at the byte rate and shifts them out MSB-first on a single bit line at clk_32f, one bit per clock. It drives the line that the serial-to-parallel receiver (serial_paralelo) samples. After reset it emits a synchronization preamble of COMMA characters (0xBC) so the receiver can align and go active. After that it sends accepted data bytes, and fills with COMMA whenever no byte is offered.

## Interface
- MIN_COMMAS, 4: number of COMMA frames sent after reset before data is accepted; must be ≥1.
- COMMA, 8'hBC: alignment and idle-fill character.

- clk_32f  input  1  bit-rate clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- data_in  input  8  byte to transmit; sampled only on an accept edge.
- valid_in  input  1  data_in holds a byte to send.
- in_ready  output  1  combinational; high in the cycle where a valid byte will be accepted on the next edge.
- data_out  output  1  serial bit, registered.
- active  output  1  registered; high once the preamble is complete.

## Operation
- Registers:
  - frm[7:0]: current frame.
  - bit_cnt[2:0]: bit index, 0..7.
  - comma_cnt: number of COMMAs loaded during SYNC; width is ceil(log2(MIN_COMMAS+1)).
  - state: SYNC or RUN.
  - data_out, active.
- Reset (reset=0), all values asynchronous:
  - frm=COMMA, bit_cnt=0, comma_cnt=1, state=SYNC.
  - data_out=0, active=0.
- Every edge out of reset:
  - data_out <= frm[7-bit_cnt].
  - bit_cnt <= bit_cnt+1, wrapping 7→0.
- Load edge: any edge with bit_cnt==7. frm takes the next frame as follows.
- In SYNC:
  - If comma_cnt<MIN_COMMAS: frm<=COMMA and comma_cnt++.
  - If comma_cnt==MIN_COMMAS: state<=RUN and active<=1. The same edge applies the RUN load rule.
- In RUN:
  - If valid_in=1: frm<=data_in (accept).
  - Otherwise: frm<=COMMA (idle fill).
  - active stays 1 until reset.
- in_ready = (bit_cnt==7) && (state==RUN || comma_cnt==MIN_COMMAS).
- Handshake: a byte transfers on an edge where valid_in && in_ready. The source must hold data_in stable through that edge. valid_in outside in_ready is ignored. A byte is never dropped or duplicated.
- A data byte equal to COMMA is transmitted unmodified. Distinguishing it is the receiver's concern.

## Timing
- With reset released before edge 1, edge k (k≥1) outputs bit (k-1) mod 8 of the current frame.
- Load edges are edges 8, 16, 24, …
- The preamble occupies edges 1..8·MIN_COMMAS.
- active rises on edge 8·MIN_COMMAS (edge 32 at the default). That same edge is the first accept opportunity.
- Accept-to-line latency: a byte accepted on edge E appears with MSB on data_out after edge E+1 and LSB after edge E+8.
- Throughput is one byte per 8 clocks. in_ready is high 1 cycle in 8.
- Reset asserted mid-frame:
  - Outputs go to reset values at once, without waiting for a clock.
  - The partial frame is abandoned.
  - After release, the full preamble repeats.
- Reset released coincident with an edge: that edge is ignored, and counting starts at the next edge.

## Configuration
- PS_TXCOUNT_EN defined:
  - Adds output tx_count [15:0].
  - tx_count increments on every accept edge and wraps 0xFFFF→0x0000.
  - Reset value is 0. COMMA fills and preamble frames are not counted.
- PS_TXCOUNT_EN undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset low for 4 clocks, then release with valid_in=0:
  - data_out repeats 1,0,1,1,1,1,0,0.
  - in_ready=0 before the cycle preceding edge 32.
  - active 0→1 at edge 32.
  - The line stays COMMA afterwards.
- valid_in=1 held with data_in=0xA5:
  - First frame after the preamble, edges 33–40, reads 1,0,1,0,0,1,0,1.
  - Every later frame is also 0xA5.
- Bytes 0x01..0x10 presented back-to-back, each advanced on accept:
  - Sixteen consecutive frames carry 0x01..0x10 MSB-first with no COMMA between them.
  - tx_count=16 when PS_TXCOUNT_EN is defined.
- In RUN, send 0x3C, drop valid_in for one accept slot, then send 0xC3:
  - Frames read 0x3C, 0xBC, 0xC3.
  - active stays 1.
- Assert reset at bit 4 of a data frame:
  - data_out=0 and active=0 immediately.
  - After release, 4 COMMAs are sent before the next accept.
- Elaborate with MIN_COMMAS=1:
  - active rises at edge 8.
  - A byte offered at that edge is accepted and starts on edge 9.

Source files
------------

// File: rtl/paralelo_serial_if.sv
// Byte-side handshake and serial line bundle for paralelo_serial.
// tx_count exists only when PS_TXCOUNT_EN is defined.
interface paralelo_serial_if;
    logic [7:0]  data_in;
    logic        valid_in;
    logic        in_ready;
    logic        data_out;
    logic        active;
`ifdef PS_TXCOUNT_EN
    logic [15:0] tx_count;

    modport master (output data_in, valid_in, input in_ready, data_out, active, tx_count);
    modport slave  (input data_in, valid_in, output in_ready, data_out, active, tx_count);
`else
    modport master (output data_in, valid_in, input in_ready, data_out, active);
    modport slave  (input data_in, valid_in, output in_ready, data_out, active);
`endif
endinterface

// File: rtl/paralelo_serial.sv
// Parallel-to-serial transmitter: COMMA preamble after reset, then MSB-first bytes with COMMA idle fill.
// Optional accepted-byte counter enabled by defining PS_TXCOUNT_EN.
module paralelo_serial #(
    parameter int unsigned MIN_COMMAS = 4,
    parameter logic [7:0]  COMMA      = 8'hBC
) (
    input logic             clk_32f,
    input logic             reset,
    paralelo_serial_if.slave bus
);
    localparam int unsigned    CW   = $clog2(MIN_COMMAS + 1);
    localparam logic [CW-1:0] LAST = CW'(MIN_COMMAS);

    typedef enum logic {SYNC, RUN} state_t;

    state_t        state;
    logic [7:0]    frm;
    logic [2:0]    bit_cnt;
    logic [CW-1:0] comma_cnt;
    logic          data_out;
    logic          active;
    logic          in_ready;
    logic          accept;
    logic          load;

    assign load     = (bit_cnt == 3'd7);
    assign in_ready = load && (state == RUN || comma_cnt == LAST);
    assign accept   = in_ready && bus.valid_in;

`ifdef PS_TXCOUNT_EN
    logic [15:0] tx_count;
    assign bus.tx_count = tx_count;
`endif

    // The last preamble load edge already behaves as a RUN load edge.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            frm       <= COMMA;
            bit_cnt   <= '0;
            comma_cnt <= CW'(1);
            data_out  <= 1'b0;
            active    <= 1'b0;
`ifdef PS_TXCOUNT_EN
            tx_count  <= '0;
`endif
        end else begin
            data_out <= frm[3'd7 - bit_cnt];
            bit_cnt  <= bit_cnt + 3'd1;
            if (load) begin
                if (state == SYNC && comma_cnt < LAST) begin
                    frm       <= COMMA;
                    comma_cnt <= comma_cnt + CW'(1);
                end else begin
                    state  <= RUN;
                    active <= 1'b1;
                    frm    <= accept ? bus.data_in : COMMA;
`ifdef PS_TXCOUNT_EN
                    if (accept) begin
                        tx_count <= tx_count + 16'd1;
                    end
`endif
                end
            end
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.data_out = data_out;
    assign bus.active   = active;
endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: default instance (MIN_COMMAS=4) and a MIN_COMMAS=1 instance.
module tb_paralelo_serial;
    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    logic reset1  = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [15:0] exp_cnt = '0;
    logic [7:0]  g;

    paralelo_serial_if bus ();
    paralelo_serial_if bus1 ();

    paralelo_serial dut (.clk_32f(clk_32f), .reset(reset), .bus(bus.slave));
    paralelo_serial #(.MIN_COMMAS(1)) dut1 (.clk_32f(clk_32f), .reset(reset1), .bus(bus1.slave));

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Eight edges starting right after a load edge; the next byte is offered while in_ready is high.
    task automatic run_frame(input logic nv, input logic [7:0] nd, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_32f); #1;
            got = {got[6:0], bus.data_out};
            if (i == 6) begin
                check("run_rdy", 16'(bus.in_ready), 16'd1);
                bus.valid_in = nv;
                bus.data_in  = nd;
                if (nv) exp_cnt++;
            end
        end
    endtask

    task automatic preamble(input logic pv, input logic [7:0] pd, input logic nv, input logic [7:0] nd);
        logic [7:0] f;
        f = '0;
        bus.valid_in = pv;
        bus.data_in  = pd;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk_32f); #1;
            f = {f[6:0], bus.data_out};
            check("pre_rdy", 16'(bus.in_ready), 16'(k == 31));
            check("pre_act", 16'(bus.active), 16'(k >= 32));
            if (k % 8 == 0) check("pre_frm", 16'(f), 16'h00BC);
            if (k == 31) begin
                bus.valid_in = nv;
                bus.data_in  = nd;
                if (nv) exp_cnt++;
            end
        end
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.data_in   = '0;
        bus1.valid_in = 1'b0;
        bus1.data_in  = '0;

        repeat (4) @(posedge clk_32f);
        #1;
        check("rst_dout", 16'(bus.data_out), 16'd0);
        check("rst_act", 16'(bus.active), 16'd0);
        check("rst_rdy", 16'(bus.in_ready), 16'd0);
`ifdef PS_TXCOUNT_EN
        check("rst_cnt", bus.tx_count, 16'd0);
`endif
        @(negedge clk_32f) reset = 1'b1;

        preamble(1'b0, 8'h00, 1'b1, 8'hA5);
        run_frame(1'b1, 8'hA5, g);
        check("a5_first", 16'(g), 16'h00A5);
        run_frame(1'b1, 8'h01, g);
        check("a5_hold", 16'(g), 16'h00A5);

        for (int n = 1; n <= 16; n++) begin
            run_frame(1'b1, (n == 16) ? 8'h3C : 8'(n + 1), g);
            check("seq", 16'(g), 16'(n));
        end
`ifdef PS_TXCOUNT_EN
        check("cnt_seq", bus.tx_count, exp_cnt);
`endif

        run_frame(1'b0, 8'h00, g);
        check("gap_3c", 16'(g), 16'h003C);
        run_frame(1'b1, 8'hC3, g);
        check("gap_fill", 16'(g), 16'h00BC);
        run_frame(1'b0, 8'h00, g);
        check("gap_c3", 16'(g), 16'h00C3);
        check("gap_act", 16'(bus.active), 16'd1);
        run_frame(1'b0, 8'h00, g);
        check("idle", 16'(g), 16'h00BC);
        run_frame(1'b1, 8'h5A, g);
        check("idle2", 16'(g), 16'h00BC);

        // 0x5A: after four edges the line holds bit index 4 (a one).
        repeat (4) @(posedge clk_32f);
        #1;
        check("mid_bit", 16'(bus.data_out), 16'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_dout", 16'(bus.data_out), 16'd0);
        check("mid_act", 16'(bus.active), 16'd0);
        check("mid_rdy", 16'(bus.in_ready), 16'd0);
`ifdef PS_TXCOUNT_EN
        check("mid_cnt", bus.tx_count, 16'd0);
`endif
        exp_cnt = '0;
        repeat (2) @(posedge clk_32f);
        @(negedge clk_32f) reset = 1'b1;

        preamble(1'b1, 8'h77, 1'b1, 8'h77);
        run_frame(1'b0, 8'h00, g);
        check("post_rst", 16'(g), 16'h0077);
`ifdef PS_TXCOUNT_EN
        check("cnt_post", bus.tx_count, exp_cnt);
`endif

        @(negedge clk_32f);
        reset1        = 1'b1;
        bus1.valid_in = 1'b1;
        bus1.data_in  = 8'hE7;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk_32f); #1;
            check("m1_rdy", 16'(bus1.in_ready), 16'(k == 7));
            check("m1_act", 16'(bus1.active), 16'(k >= 8));
        end
        g = '0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk_32f); #1;
            g = {g[6:0], bus1.data_out};
        end
        check("m1_frm", 16'(g), 16'h00E7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
